// File: rtl/awsctrl_pkg.sv
// rtl/awsctrl_pkg.sv - shared types and helpers for the awsctrl_mc serial control transmitter
// Contents: state_t (FSM encoding), MAX_VEC/MAX_DW (helper limits), clog2(), ch_slice()
package awsctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAPW  = 2'd3
    } state_t;

    // ch_slice works on a fixed-width container so it needs no parameters of its own.
    localparam int MAX_VEC = 256;
    localparam int MAX_DW  = 32;

    // Minimum result of 1 so a single-channel build still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Channel idx of a packed vector of dw-bit channels, zero-extended to MAX_DW.
    function automatic logic [MAX_DW-1:0] ch_slice(input logic [MAX_VEC-1:0] vec,
                                                   input int idx, input int dw);
        logic [MAX_VEC-1:0] s;
        logic [MAX_DW:0]    m;
        s = vec >> (idx * dw);
        m = (33'd1 << dw) - 33'd1;
        return s[MAX_DW-1:0] & m[MAX_DW-1:0];
    endfunction

endpackage

// File: rtl/awsctrl_mc_if.sv
// rtl/awsctrl_mc_if.sv - serial link bundle between transmitter and chip-select slaves
// Signals: sclk (serial clock), sdo (serial data), cs_n[NCH] (active-low chip selects)
// Modports: master drives the link, slave observes it.
interface awsctrl_mc_if #(parameter int NCH = 3);
    logic           sclk;
    logic           sdo;
    logic [NCH-1:0] cs_n;

    modport master (output sclk, sdo, cs_n);
    modport slave  (input  sclk, sdo, cs_n);
endinterface

// File: rtl/awsctrl_tick.sv
// rtl/awsctrl_tick.sv - runtime-programmable tick divider
// Ports: w_clk, w_rstn (async active-low), div (period = div+1 clocks), tick (1-cycle strobe)
module awsctrl_tick #(
    parameter int DIVW = 10
) (
    input  logic            w_clk,
    input  logic            w_rstn,
    input  logic [DIVW-1:0] div,
    output logic            tick
);

    logic [DIVW-1:0] divcnt;

    // Compare with >= so a lowered div takes effect at once instead of wrapping the counter.
    assign tick = (divcnt >= div);

    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn)   divcnt <= '0;
        else if (tick) divcnt <= '0;
        else           divcnt <= divcnt + DIVW'(1);
    end

endmodule

// File: rtl/awsctrl_mc.sv
// rtl/awsctrl_mc.sv - multi-channel serial control transmitter (round-robin or on-change)
// Ports: w_clk, w_rstn (async active-low), en, mode (0 round-robin / 1 changed-only),
//        div (tick period div+1), ctrl_val (NCH packed DW-bit channels),
//        spi (sclk/sdo/cs_n master link), busy, ch_idx (current/last channel), frame_done
module awsctrl_mc
    import awsctrl_pkg::*;
#(
    parameter  int NCH  = 3,
    parameter  int DW   = 8,
    parameter  int DIVW = 10,
    parameter  int GAP  = 2,
    localparam int CW   = clog2(NCH)
) (
    input  logic              w_clk,
    input  logic              w_rstn,
    input  logic              en,
    input  logic              mode,
    input  logic [DIVW-1:0]   div,
    input  logic [NCH*DW-1:0] ctrl_val,
    awsctrl_mc_if.master      spi,
    output logic              busy,
    output logic [CW-1:0]     ch_idx,
    output logic              frame_done
);

    localparam int BW = clog2(DW);
    localparam int GW = clog2(GAP + 1);

    logic tick;

    awsctrl_tick #(.DIVW(DIVW)) u_tick (
        .w_clk  (w_clk),
        .w_rstn (w_rstn),
        .div    (div),
        .tick   (tick)
    );

    state_t         state_q, state_d;
    logic [DW-1:0]  sh_q, sh_d;
    logic [DW-1:0]  sent_q [NCH];
    logic [DW-1:0]  sent_d [NCH];
    logic [NCH-1:0] vld_q, vld_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [NCH-1:0] cs_q, cs_d;
    logic           sdo_q, sdo_d, sclk_q, sclk_d, fd_q, fd_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [GW-1:0]  gap_q, gap_d;

    logic [DW-1:0]  slice [NCH];
    logic [NCH-1:0] pend;
    logic           cand_vld;
    logic [CW-1:0]  cand;

    // A channel is pending until its current value has gone out at least once.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            slice[i] = DW'(ch_slice(MAX_VEC'(ctrl_val), i, DW));
            pend[i]  = !vld_q[i] || (slice[i] != sent_q[i]);
        end
    end

    // Round-robin scan starting after the last channel sent; in mode 0 the first step always wins.
    always_comb begin
        cand_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!cand_vld && (!mode || pend[(int'(idx_q) + k) % NCH])) begin
                cand_vld = 1'b1;
                cand     = CW'((int'(idx_q) + k) % NCH);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        sent_d  = sent_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        cs_d    = cs_q;
        sdo_d   = sdo_q;
        sclk_d  = sclk_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        fd_d    = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (en && cand_vld) begin
                        sh_d         = slice[cand];
                        sent_d[cand] = slice[cand];
                        vld_d[cand]  = 1'b1;
                        idx_d        = cand;
                        cs_d         = '1;
                        cs_d[cand]   = 1'b0;
                        sdo_d        = slice[cand][DW-1];
                        bit_d        = BW'(DW - 1);
                        state_d      = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sclk_d = !sclk_q;
                    // Data only moves on the falling edge, leaving it stable across the slave's rising sample.
                    if (sclk_q) begin
                        if (bit_q == '0) begin
                            state_d = ST_HOLD;
                        end else begin
                            bit_d = bit_q - BW'(1);
                            sdo_d = sh_q[bit_d];
                        end
                    end
                end
                ST_HOLD: begin
                    cs_d  = '1;
                    sdo_d = 1'b0;
                    fd_d  = 1'b1;
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = GW'(GAP - 1);
                        state_d = ST_GAPW;
                    end
                end
                ST_GAPW: begin
                    if (gap_q == '0) state_d = ST_IDLE;
                    else             gap_d   = gap_q - GW'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            for (int i = 0; i < NCH; i++) sent_q[i] <= '0;
            vld_q   <= '0;
            idx_q   <= CW'(NCH - 1);
            cs_q    <= '1;
            sdo_q   <= 1'b0;
            sclk_q  <= 1'b0;
            fd_q    <= 1'b0;
            bit_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            sent_q  <= sent_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            cs_q    <= cs_d;
            sdo_q   <= sdo_d;
            sclk_q  <= sclk_d;
            fd_q    <= fd_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
        end
    end

    assign spi.sclk   = sclk_q;
    assign spi.sdo    = sdo_q;
    assign spi.cs_n   = cs_q;
    assign busy       = (state_q != ST_IDLE);
    assign ch_idx     = idx_q;
    assign frame_done = fd_q;

endmodule
